intl_cfg_axi_master: RTL and testbench

INTL_CFG_AXI_MASTER -- requirements
Module: intl_cfg_axi_master

---
 rtl/intl_cfg_axi_master.sv | 156 +++++++++++++++
 tb/tb_intl_cfg_axi_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/intl_cfg_axi_master.sv
// AXI4-Lite single-outstanding command master for the interlock register slave.
// A command (read or write) is taken in IDLE, issued on AXI, and completed with a
// one-cycle o_rsp_valid pulse from DONE. Optional macro INTL_CFG_TIMEOUT_EN adds a
// response-wait limit of TIMEOUT_CYCLES clocks. That limit covers every state between
// acceptance and DONE, and an expiry completes the command with o_rsp_err = 1.
module intl_cfg_axi_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  output logic                            o_rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                            o_rsp_err,
  output logic                            o_busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                      m00_axi_awprot,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t                          state, state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic                            awvalid_q, wvalid_q, arvalid_q, err_q;
  logic                            accept, aw_done, w_done, tmo;

  assign accept  = i_cmd_valid & (state == IDLE);
  // A channel counts as finished once its valid is gone or it handshakes this cycle.
  assign aw_done = ~awvalid_q | m00_axi_awready;
  assign w_done  = ~wvalid_q  | m00_axi_wready;

`ifdef INTL_CFG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting = (state != IDLE) && (state != DONE);
  assign tmo     = waiting && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Clocks spent waiting on the slave since the command was accepted.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn)  tmo_cnt <= '0;
    else if (accept)       tmo_cnt <= '0;
    else if (waiting)      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) state <= IDLE;
    else                  state <= state_nxt;
  end

  // Next state. A real handshake takes priority over an expiry on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cmd_valid) state_nxt = i_cmd_wr ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done)  state_nxt = WR_RESP;
               else if (tmo)           state_nxt = DONE;
      WR_RESP: if (m00_axi_bvalid || tmo) state_nxt = DONE;
      RD_REQ:  if (m00_axi_arready)    state_nxt = RD_DATA;
               else if (tmo)           state_nxt = DONE;
      RD_DATA: if (m00_axi_rvalid || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request valids: raised on acceptance, each dropped on its own handshake or on expiry.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else if (accept) begin
      awvalid_q <= i_cmd_wr;
      wvalid_q  <= i_cmd_wr;
      arvalid_q <= ~i_cmd_wr;
    end else begin
      if (m00_axi_awready || tmo) awvalid_q <= 1'b0;
      if (m00_axi_wready  || tmo) wvalid_q  <= 1'b0;
      if (m00_axi_arready || tmo) arvalid_q <= 1'b0;
    end
  end

  // Command capture; address and data stay put for the whole transaction.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= i_cmd_addr;
      wdata_q <= i_cmd_wdata;
    end
  end

  // Response capture; read data changes only when a read actually completes.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (m00_axi_bvalid && m00_axi_bready) begin
      err_q   <= |m00_axi_bresp;
    end else if (m00_axi_rvalid && m00_axi_rready) begin
      err_q   <= |m00_axi_rresp;
      rdata_q <= m00_axi_rdata;
    end else if (tmo && state_nxt == DONE) begin
      err_q   <= 1'b1;
    end
  end

  assign o_cmd_ready     = (state == IDLE);
  assign o_busy          = (state != IDLE);
  assign o_rsp_valid     = (state == DONE);
  assign o_rsp_err       = (state == DONE) & err_q;
  assign o_rsp_rdata     = rdata_q;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_bready  = (state == WR_RESP);
  assign m00_axi_rready  = (state == RD_DATA);

endmodule

// File: tb/tb_intl_cfg_axi_master.sv
// Bench for intl_cfg_axi_master: table of transactions against a delay-programmable
// AXI4-Lite slave, scoreboard of expected completions, plus timeout and reset sequences.
module tb_intl_cfg_axi_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [6:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  intl_cfg_axi_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(7), .TIMEOUT_CYCLES(16)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready));

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          a_dly;   // awready (write) or arready (read) delay
    int          w_dly;   // wready delay (write only)
    int          r_dly;   // bvalid (write) or rvalid (read) delay
    logic [1:0]  resp;
    logic [31:0] sdata;   // slave read data
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[8];
  exp_t sbq[$];
  int   checks = 0, fails = 0;
  int   rsp_count = 0, bready_rises = 0;
  logic bready_prev = 1'b0;

  always @(negedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

  always @(posedge clk) begin
    bready_prev <= bready;
    if (bready && !bready_prev) bready_rises <= bready_rises + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a command and return #1 after the accepting edge.
  task automatic issue(input logic wr, input logic [6:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for the completion pulse, pop the scoreboard and compare.
  task automatic wait_rsp(input string tag, output int ready_hi, output int cycles);
    int n = 0;
    exp_t e;
    ready_hi = 0; cycles = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
      if (cmd_ready && !rsp_valid) ready_hi++;
      if (arvalid) cycles++;
    end
    if (!rsp_valid) chk({tag, "_rsp_timeout"}, 0, 1);
    else if (sbq.size() == 0) chk({tag, "_rsp_unexpected"}, 1, 0);
    else begin
      e = sbq.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, rsp_err, e.err);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int rc0, br0, rhi, cyc;
    string tag;
    tag = $sformatf("t%0d", idx);
    rc0 = rsp_count; br0 = bready_rises;
    issue(v.wr, v.addr, v.wdata);
    sbq.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    fork
      if (v.wr) begin : aw_ch
        int n = 0;
        while (!awvalid && n < 64) begin @(posedge clk); #1; n++; end
        repeat (v.a_dly) begin @(posedge clk); #1; end
        chk({tag, "_awvalid_held"}, awvalid, 1);
        chk({tag, "_awaddr"}, awaddr, v.addr);
        awready = 1'b1; @(posedge clk); #1; awready = 1'b0;
        chk({tag, "_awvalid_drop"}, awvalid, 0);
      end
      if (v.wr) begin : w_ch
        int n = 0;
        while (!wvalid && n < 64) begin @(posedge clk); #1; n++; end
        repeat (v.w_dly) begin @(posedge clk); #1; end
        chk({tag, "_wdata"}, {wstrb, wdata}, {4'hF, v.wdata});
        wready = 1'b1; @(posedge clk); #1; wready = 1'b0;
        chk({tag, "_wvalid_drop"}, wvalid, 0);
        if (v.a_dly > v.w_dly) chk({tag, "_awvalid_after_w"}, awvalid, 1);
      end
      if (v.wr) begin : b_ch
        int n = 0;
        while (!bready && n < 64) begin @(posedge clk); #1; n++; end
        chk({tag, "_req_clear_at_bready"}, {awvalid, wvalid}, 2'b00);
        repeat (v.r_dly) begin @(posedge clk); #1; end
        bresp = v.resp; bvalid = 1'b1; @(posedge clk); #1; bvalid = 1'b0; bresp = 2'b00;
      end
      if (!v.wr) begin : ar_ch
        int n = 0;
        while (!arvalid && n < 64) begin @(posedge clk); #1; n++; end
        repeat (v.a_dly) begin @(posedge clk); #1; end
        chk({tag, "_araddr"}, {arvalid, arprot, araddr}, {1'b1, 3'b000, v.addr});
        arready = 1'b1; @(posedge clk); #1; arready = 1'b0;
        chk({tag, "_arvalid_drop"}, arvalid, 0);
      end
      if (!v.wr) begin : r_ch
        int n = 0;
        while (!rready && n < 64) begin @(posedge clk); #1; n++; end
        repeat (v.r_dly) begin @(posedge clk); #1; end
        rdata = v.sdata; rresp = v.resp; rvalid = 1'b1;
        @(posedge clk); #1; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      end
      wait_rsp(tag, rhi, cyc);
    join
    @(negedge clk); @(negedge clk);
    chk({tag, "_cmd_ready_low_while_busy"}, rhi, 0);
    chk({tag, "_single_pulse"}, rsp_count - rc0, 1);
    chk({tag, "_bready_phases"}, bready_rises - br0, v.wr ? 1 : 0);
  endtask

  initial begin
    int rc0, rhi, cyc;
    vec_t v;
    vecs[0] = '{1'b1, 7'h08, 32'h0000_1234, 0, 0, 0, 2'b00, 32'h0,         32'h0,         1'b0};
    vecs[1] = '{1'b1, 7'h0C, 32'hA5A5_0001, 3, 0, 1, 2'b00, 32'h0,         32'h0,         1'b0};
    vecs[2] = '{1'b0, 7'h10, 32'h0,         0, 0, 0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 7'h14, 32'h5555_AAAA, 0, 2, 0, 2'b10, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{1'b0, 7'h20, 32'h0,         1, 0, 2, 2'b10, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[5] = '{1'b1, 7'h7C, 32'hFFFF_FFFF, 2, 2, 3, 2'b11, 32'h0,         32'h1234_5678, 1'b1};
    vecs[6] = '{1'b0, 7'h7C, 32'h0,         2, 0, 0, 2'b00, 32'h0,         32'h0,         1'b0};
    vecs[7] = '{1'b0, 7'h04, 32'h0,         0, 0, 1, 2'b01, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};

    #3;
    chk("reset_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, busy, cmd_ready}, 9'b0_0000_0001);
    chk("reset_data", {awaddr, araddr, wdata, rsp_rdata}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {cmd_ready, busy, rsp_valid}, 3'b100);

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

`ifdef INTL_CFG_TIMEOUT_EN
    // Read that the slave never accepts: arvalid for 16 clocks, then an error completion.
    rc0 = rsp_count;
    issue(1'b0, 7'h30, 32'h0);
    sbq.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1});
    wait_rsp("tmo", rhi, cyc);
    chk("tmo_arvalid_cycles", cyc, 16);
    chk("tmo_arvalid_dropped", {arvalid, rready}, 2'b00);
    @(negedge clk); @(negedge clk);
    chk("tmo_single_pulse", rsp_count - rc0, 1);
`endif

    v = '{1'b0, 7'h18, 32'h0, 1, 0, 0, 2'b00, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    run_txn(8, v);

    // Reset while waiting on the write response.
    rc0 = rsp_count;
    awready = 1'b1; wready = 1'b1;
    issue(1'b1, 7'h40, 32'h1111_2222);
    cyc = 0;
    while (!bready && cyc < 64) begin @(negedge clk); cyc++; end
    chk("rst_reached_wr_resp", bready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, busy, cmd_ready}, 9'b0_0000_0001);
    chk("rst_async_data", {awaddr, araddr, wdata, rsp_rdata}, '0);
    awready = 1'b0; wready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_rsp", rsp_count - rc0, 0);
    chk("rst_ready_after", {cmd_ready, busy}, 2'b10);

    v = '{1'b0, 7'h24, 32'h0, 0, 0, 0, 2'b00, 32'h600D_CAFE, 32'h600D_CAFE, 1'b0};
    run_txn(9, v);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
